dmem_arbiter: RTL and testbench

- Shares the single-port data memory (256 x 8, combinational read, write on posedge) between the core load/store path and a host/DMA port used for preload and readback.
- Round-robin arbitration, bounded host burst locking, and a core stall output that the PC/control path uses to freeze fetch.
- Sits between Control/reg_file outputs and dat_mem; counts core stall cycles for performance checking.

---
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core load/store path and a host/DMA port.
// Zero-latency round-robin grant, host burst lock bounded to MAX_LOCK grants, saturating core stall counter.
module dmem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_LOCK = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             core_req,
    input  logic             core_we,
    input  logic [AW-1:0]    core_addr,
    input  logic [DW-1:0]    core_wdata,
    output logic             core_gnt,
    output logic [DW-1:0]    core_rdata,
    output logic             core_stall,
    input  logic             host_req,
    input  logic             host_we,
    input  logic             host_lock,
    input  logic [AW-1:0]    host_addr,
    input  logic [DW-1:0]    host_wdata,
    output logic             host_gnt,
    output logic [DW-1:0]    host_rdata,
    output logic             mem_wr_en,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_dat_in,
    input  logic [DW-1:0]    mem_dat_out,
    output logic             lock_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int LCW = $clog2(MAX_LOCK + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic [LCW-1:0]     lock_cnt_q, lock_cnt_d;
    logic               rearm_block_q, rearm_block_d;
    logic               lock_timeout_q, lock_timeout_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    // last_q == 1 means the host was served most recently, so the core wins a tie.
    always_comb begin
        core_gnt = 1'b0;
        host_gnt = 1'b0;
        if (!reset) begin
            if (state_q == LOCKED && host_req) begin
                host_gnt = 1'b1;
            end else if (core_req && host_req) begin
                if (last_q) core_gnt = 1'b1;
                else        host_gnt = 1'b1;
            end else begin
                core_gnt = core_req;
                host_gnt = host_req;
            end
        end
    end

    always_comb begin
        mem_wr_en  = 1'b0;
        mem_addr   = '0;
        mem_dat_in = '0;
        if (core_gnt) begin
            mem_wr_en  = core_we;
            mem_addr   = core_addr;
            mem_dat_in = core_wdata;
        end else if (host_gnt) begin
            mem_wr_en  = host_we;
            mem_addr   = host_addr;
            mem_dat_in = host_wdata;
        end
    end

    assign core_rdata   = core_gnt ? mem_dat_out : '0;
    assign host_rdata   = host_gnt ? mem_dat_out : '0;
    assign core_stall   = !reset && core_req && !core_gnt;
    assign lock_timeout = lock_timeout_q;
    assign stall_cnt    = stall_cnt_q;

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        lock_cnt_d     = lock_cnt_q;
        rearm_block_d  = rearm_block_q;
        lock_timeout_d = lock_timeout_q;
        stall_cnt_d    = stall_cnt_q;

        if (core_gnt)      last_d = 1'b0;
        else if (host_gnt) last_d = 1'b1;

        if (core_stall && stall_cnt_q != {CNT_W{1'b1}})
            stall_cnt_d = stall_cnt_q + CNT_W'(1);

        if (!host_lock) rearm_block_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (host_gnt && host_lock && !rearm_block_q) begin
                    state_d    = LOCKED;
                    lock_cnt_d = LCW'(1);
                end
            end
            LOCKED: begin
                if (!host_req || !host_lock) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LCW'(MAX_LOCK - 1)) begin
                    // This grant is the MAX_LOCK-th of the burst: force release and block re-lock.
                    state_d        = IDLE;
                    lock_cnt_d     = '0;
                    lock_timeout_d = 1'b1;
                    rearm_block_d  = 1'b1;
                end else begin
                    lock_cnt_d = lock_cnt_q + LCW'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            last_q         <= 1'b1;
            lock_cnt_q     <= '0;
            rearm_block_q  <= 1'b0;
            lock_timeout_q <= 1'b0;
            stall_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            lock_cnt_q     <= lock_cnt_d;
            rearm_block_q  <= rearm_block_d;
            lock_timeout_q <= lock_timeout_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_dmem_arbiter;
    localparam int MAX_LOCK = 16;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, core_req, core_we, host_req, host_we, host_lock;
    logic [7:0] core_addr, core_wdata, host_addr, host_wdata;
    logic       core_gnt, core_stall, host_gnt, mem_wr_en, lock_timeout;
    logic [7:0] core_rdata, host_rdata, mem_addr, mem_dat_in, mem_dat_out;
    logic [15:0] stall_cnt;
    logic       s_core_gnt, s_core_stall, s_host_gnt, s_mem_wr_en, s_lock_timeout;
    logic [7:0] s_core_rdata, s_host_rdata, s_mem_addr, s_mem_dat_in, s_mem_dat_out;
    logic [3:0] s_stall_cnt;

    logic [7:0] mem [256];
    assign mem_dat_out   = mem[mem_addr];
    assign s_mem_dat_out = mem[s_mem_addr];
    always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_dat_in;

    dmem_arbiter #(.AW(8), .DW(8), .MAX_LOCK(MAX_LOCK), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rdata(core_rdata), .core_stall(core_stall),
        .host_req(host_req), .host_we(host_we), .host_lock(host_lock), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_dat_in(mem_dat_in), .mem_dat_out(mem_dat_out),
        .lock_timeout(lock_timeout), .stall_cnt(stall_cnt));

    dmem_arbiter #(.AW(8), .DW(8), .MAX_LOCK(MAX_LOCK), .CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(s_core_gnt), .core_rdata(s_core_rdata), .core_stall(s_core_stall),
        .host_req(host_req), .host_we(host_we), .host_lock(host_lock), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(s_host_gnt), .host_rdata(s_host_rdata), .mem_wr_en(s_mem_wr_en),
        .mem_addr(s_mem_addr), .mem_dat_in(s_mem_dat_in), .mem_dat_out(s_mem_dat_out),
        .lock_timeout(s_lock_timeout), .stall_cnt(s_stall_cnt));

    int checks = 0;
    int failures = 0;

    // Reference model: who was served last, how many grants the current burst has had, sticky flags.
    logic [7:0] ref_mem [256];
    bit  m_last_host, m_block, m_tmo;
    int  m_burst, m_stalls;
    bit  e_c, e_h, e_we, e_stall;
    logic [7:0] e_addr, e_wd, e_crd, e_hrd;

    function automatic int sat(input int v, input int w);
        int mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic void model_eval();
        e_c = 1'b0;
        e_h = 1'b0;
        if (!reset) begin
            if (m_burst > 0 && host_req) e_h = 1'b1;
            else if (core_req && host_req) begin
                if (m_last_host) e_c = 1'b1; else e_h = 1'b1;
            end else begin
                e_c = core_req;
                e_h = host_req;
            end
        end
        e_we    = e_c ? core_we    : (e_h ? host_we    : 1'b0);
        e_addr  = e_c ? core_addr  : (e_h ? host_addr  : 8'h00);
        e_wd    = e_c ? core_wdata : (e_h ? host_wdata : 8'h00);
        e_crd   = e_c ? ref_mem[core_addr] : 8'h00;
        e_hrd   = e_h ? ref_mem[host_addr] : 8'h00;
        e_stall = !reset && core_req && !e_c;
    endfunction

    function automatic void model_commit();
        if (reset) begin
            m_last_host = 1'b1; m_burst = 0; m_block = 1'b0; m_tmo = 1'b0; m_stalls = 0;
            return;
        end
        if (e_we) ref_mem[e_addr] = e_wd;
        if (e_stall) m_stalls++;
        if (m_burst > 0) begin
            if (!host_req || !host_lock) m_burst = 0;
            else begin
                m_burst++;
                if (m_burst == MAX_LOCK) begin
                    m_burst = 0; m_tmo = 1'b1; m_block = 1'b1;
                end
            end
        end else if (e_h && host_lock && !m_block) m_burst = 1;
        if (!host_lock) m_block = 1'b0;
        if (e_c) m_last_host = 1'b0;
        else if (e_h) m_last_host = 1'b1;
    endfunction

    task automatic drive(input bit r, input bit cr, input bit cw, input logic [7:0] ca, input logic [7:0] cd,
                         input bit hr, input bit hw, input bit hl, input logic [7:0] ha, input logic [7:0] hd);
        reset = r; core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        host_req = hr; host_we = hw; host_lock = hl; host_addr = ha; host_wdata = hd;
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        settle();
        tick();
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 1, 8'h21, 8'h5A, 1, 1, 1, 8'h22, 8'h3C);
            settle();
            checks++;
            if ({core_gnt, host_gnt, mem_wr_en, core_stall} !== 4'b0000 || {mem_addr, mem_dat_in, core_rdata, host_rdata} !== 32'h0) begin
                failures++;
                $display("FAIL reset_outputs gnt=%b%b we=%b stall=%b addr=%h din=%h crd=%h hrd=%h required all zero",
                         core_gnt, host_gnt, mem_wr_en, core_stall, mem_addr, mem_dat_in, core_rdata, host_rdata);
            end
            tick();
        end
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        settle();
        checks++;
        if (stall_cnt !== 16'd0 || lock_timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_state stall_cnt=%0d lock_timeout=%b required 0/0", stall_cnt, lock_timeout);
        end
        checks++;
        if (mem[8'h21] !== 8'h00 || mem[8'h22] !== 8'h00) begin
            failures++;
            $display("FAIL reset_write_suppressed mem21=%h mem22=%h required 00/00", mem[8'h21], mem[8'h22]);
        end
        tick();
    endtask

    task automatic test_core_rw();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, (i == 0), 8'h10, 8'hA5, 0, 0, 0, 8'h00, 8'h00);
            settle();
            checks++;
            if (core_gnt !== 1'b1 || mem_wr_en !== (i == 0) || mem_addr !== 8'h10) begin
                failures++;
                $display("FAIL core_rw_%0d gnt=%b we=%b addr=%h required 1/%0d/10", i, core_gnt, mem_wr_en, mem_addr, (i == 0));
            end
            if (i == 1) begin
                checks++;
                if (core_rdata !== 8'hA5) begin
                    failures++;
                    $display("FAIL core_readback got=%h required=a5", core_rdata);
                end
            end
            tick();
        end
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        settle();
        checks++;
        if (stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL core_rw_stall got=%0d required=0", stall_cnt);
        end
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 8'h10, 8'h00, 1, 0, 0, 8'h11, 8'h00);
            settle();
            checks++;
            if ({core_gnt, host_gnt, core_stall} !== ((i % 2 == 0) ? 3'b100 : 3'b011)) begin
                failures++;
                $display("FAIL round_robin_%0d gnt=%b%b stall=%b required core=%0d", i, core_gnt, host_gnt, core_stall, (i % 2 == 0));
            end
            tick();
        end
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        settle();
        checks++;
        if (stall_cnt !== 16'd2) begin
            failures++;
            $display("FAIL round_robin_stall got=%0d required=2", stall_cnt);
        end
        tick();
    endtask

    task automatic test_lock_burst();
        do_reset();
        drive(0, 1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        settle(); tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 8'h10, 8'h00, 1, 1, 1, 8'(i), 8'($urandom));
            settle();
            checks++;
            if ({core_gnt, host_gnt, mem_wr_en} !== 3'b011 || mem_addr !== 8'(i)) begin
                failures++;
                $display("FAIL lock_burst_%0d gnt=%b%b we=%b addr=%h required host write to %h", i, core_gnt, host_gnt, mem_wr_en, mem_addr, 8'(i));
            end
            tick();
        end
        drive(0, 1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        settle();
        checks++;
        if (core_gnt !== 1'b1 || host_gnt !== 1'b0) begin
            failures++;
            $display("FAIL lock_release gnt=%b%b required 10", core_gnt, host_gnt);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'(i), 8'h00);
            settle();
            checks++;
            if (host_rdata !== e_hrd || stall_cnt !== 16'd5 || lock_timeout !== 1'b0) begin
                failures++;
                $display("FAIL lock_burst_read_%0d hrd=%h stall_cnt=%0d tmo=%b required %h/5/0", i, host_rdata, stall_cnt, lock_timeout, e_hrd);
            end
            tick();
        end
    endtask

    task automatic test_lock_timeout();
        do_reset();
        drive(0, 1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        settle(); tick();
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 0, 8'h10, 8'h00, 1, 0, 1, 8'h20, 8'h00);
            settle();
            checks++;
            if (core_gnt !== (i >= 16 && i % 2 == 0) || host_gnt !== (i < 16 || i % 2 == 1)) begin
                failures++;
                $display("FAIL lock_timeout_seq_%0d gnt=%b%b required core=%0d", i, core_gnt, host_gnt, (i >= 16 && i % 2 == 0));
            end
            tick();
        end
        drive(0, 1, 0, 8'h10, 8'h00, 1, 0, 0, 8'h20, 8'h00);
        settle();
        checks++;
        if (lock_timeout !== 1'b1 || core_gnt !== 1'b1 || stall_cnt !== 16'(sat(m_stalls, 16))) begin
            failures++;
            $display("FAIL lock_timeout_flag tmo=%b core_gnt=%b stall_cnt=%0d required 1/1/%0d", lock_timeout, core_gnt, stall_cnt, sat(m_stalls, 16));
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0, 8'h10, 8'h00, 1, 0, 1, 8'h20, 8'h00);
            settle();
            checks++;
            if (host_gnt !== 1'b1 || host_gnt !== e_h) begin
                failures++;
                $display("FAIL lock_rearm_%0d host_gnt=%b required 1", i, host_gnt);
            end
            tick();
        end
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        settle(); tick();
    endtask

    task automatic test_reset_midburst();
        drive(0, 1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        settle(); tick();
        for (int i = 0; i < 3; i++) begin
            drive((i == 2), 1, 1, 8'h30, 8'h77, 1, 1, 1, 8'h31, 8'h66);
            settle();
            checks++;
            if ((i < 2 && host_gnt !== 1'b1) || (i == 2 && {core_gnt, host_gnt, mem_wr_en} !== 3'b000)) begin
                failures++;
                $display("FAIL midburst_%0d gnt=%b%b we=%b required %s", i, core_gnt, host_gnt, mem_wr_en, (i < 2) ? "host" : "none");
            end
            tick();
        end
        drive(0, 1, 0, 8'h10, 8'h00, 1, 0, 0, 8'h31, 8'h00);
        settle();
        checks++;
        if (core_gnt !== 1'b1 || lock_timeout !== 1'b0 || stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL midburst_after_reset core_gnt=%b tmo=%b stall_cnt=%0d required 1/0/0", core_gnt, lock_timeout, stall_cnt);
        end
        tick();
    endtask

    task automatic test_stall_saturation();
        do_reset();
        for (int i = 0; i < 38; i++) begin
            drive(0, 1, 0, 8'h10, 8'h00, 1, 0, 0, 8'h11, 8'h00);
            settle(); tick();
        end
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        settle();
        checks++;
        if (s_stall_cnt !== 4'd15 || stall_cnt !== 16'd19) begin
            failures++;
            $display("FAIL stall_saturation small=%0d large=%0d required 15/19", s_stall_cnt, stall_cnt);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                  8'($urandom_range(0, 15)), 8'($urandom), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                  ($urandom_range(0, 9) < 7), 8'($urandom_range(0, 15)), 8'($urandom));
            settle();
            checks++;
            if ({core_gnt, host_gnt, mem_wr_en, core_stall, lock_timeout} !== {e_c, e_h, e_we, e_stall, m_tmo} ||
                {mem_addr, mem_dat_in, core_rdata, host_rdata} !== {e_addr, e_wd, e_crd, e_hrd} ||
                stall_cnt !== 16'(sat(m_stalls, 16))) begin
                failures++;
                $display("FAIL random_%0d got gnt=%b%b we=%b stall=%b tmo=%b a=%h d=%h crd=%h hrd=%h cnt=%0d required %b%b %b %b %b %h %h %h %h %0d",
                         i, core_gnt, host_gnt, mem_wr_en, core_stall, lock_timeout, mem_addr, mem_dat_in, core_rdata, host_rdata, stall_cnt,
                         e_c, e_h, e_we, e_stall, m_tmo, e_addr, e_wd, e_crd, e_hrd, sat(m_stalls, 16));
            end
            checks++;
            if ({s_core_gnt, s_host_gnt, s_mem_wr_en, s_core_stall, s_lock_timeout} !== {e_c, e_h, e_we, e_stall, m_tmo} ||
                {s_mem_addr, s_mem_dat_in, s_core_rdata, s_host_rdata} !== {e_addr, e_wd, e_crd, e_hrd} ||
                s_stall_cnt !== 4'(sat(m_stalls, 4))) begin
                failures++;
                $display("FAIL random_small_%0d got gnt=%b%b cnt=%0d required %b%b %0d", i, s_core_gnt, s_host_gnt, s_stall_cnt, e_c, e_h, sat(m_stalls, 4));
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        m_last_host = 1'b1; m_burst = 0; m_block = 1'b0; m_tmo = 1'b0; m_stalls = 0;
        drive(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        test_reset();
        test_core_rw();
        test_round_robin();
        test_lock_burst();
        test_lock_timeout();
        test_reset_midburst();
        test_stall_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
